// File: rtl/if_pc_gen_pkg.sv
// Shared fetch-stage types: address width, reset PC default, stall and BTB counter encodings.
// No logic; counter saturation helper is pure combinational.
// No flow control; imported by if_pc_gen, if_btb and the bus interface.
package if_pc_gen_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] addr_t;

  localparam addr_t RESET_PC_DEF = 32'h0000_0000;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {
    CNT_SNT = 2'd0,
    CNT_WNT = 2'd1,
    CNT_WT  = 2'd2,
    CNT_ST  = 2'd3
  } cnt_e;

  function automatic cnt_e cnt_step(input cnt_e c, input logic taken);
    cnt_e r;
    r = c;
    if (taken) begin
      if (c != CNT_ST) r = cnt_e'(c + 2'd1);
    end else begin
      if (c != CNT_SNT) r = cnt_e'(c - 2'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/if_pc_gen_if.sv
// Fetch PC generator bus: CTRL/EX corrections and BTB updates in, fetch PC and prediction out.
// Wires only; master is the CTRL/EX/IF-ID side, slave is the PC generator.
// No handshake: stall_i is the only backpressure, sampled every cycle.
interface if_pc_gen_if;

  logic [5:0]             stall_i;
  logic                   flush_i;
  if_pc_gen_pkg::addr_t   flush_pc_i;
  logic                   branch_redirect_i;
  if_pc_gen_pkg::addr_t   branch_redirect_pc_i;
  logic                   bp_update_i;
  if_pc_gen_pkg::addr_t   bp_update_pc_i;
  logic                   bp_update_taken_i;
  if_pc_gen_pkg::addr_t   bp_update_target_i;

  if_pc_gen_pkg::addr_t   pc_o;
  logic                   ce_o;
  if_pc_gen_pkg::addr_t   next_pc_o;
  logic                   next_taken_o;
  logic                   branch_slot_end_o;

  modport master (
    output stall_i, flush_i, flush_pc_i, branch_redirect_i, branch_redirect_pc_i,
           bp_update_i, bp_update_pc_i, bp_update_taken_i, bp_update_target_i,
    input  pc_o, ce_o, next_pc_o, next_taken_o, branch_slot_end_o
  );

  modport slave (
    input  stall_i, flush_i, flush_pc_i, branch_redirect_i, branch_redirect_pc_i,
           bp_update_i, bp_update_pc_i, bp_update_taken_i, bp_update_target_i,
    output pc_o, ce_o, next_pc_o, next_taken_o, branch_slot_end_o
  );

endinterface

// File: rtl/if_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters; one lookup and one update port.
// Lookup is combinational; updates land on the next rising edge (same-cycle lookup sees old data).
// No backpressure: an update is accepted every cycle it is presented.
module if_btb
  import if_pc_gen_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic  ck_i,
  input  logic  rs_n_i,
  input  addr_t lkp_pc_i,
  output logic  lkp_taken_o,
  output addr_t lkp_target_o,
  input  logic  upd_vld_i,
  input  addr_t upd_pc_i,
  input  logic  upd_taken_i,
  input  addr_t upd_target_i
);

  localparam int TAG_W = XLEN - IDX_W - 2;
  typedef logic [TAG_W-1:0] tag_t;

  logic  valid_q  [ENTRIES];
  logic  valid_d  [ENTRIES];
  tag_t  tag_q    [ENTRIES];
  tag_t  tag_d    [ENTRIES];
  addr_t target_q [ENTRIES];
  addr_t target_d [ENTRIES];
  cnt_e  cnt_q    [ENTRIES];
  cnt_e  cnt_d    [ENTRIES];

  logic [IDX_W-1:0] lkp_idx;
  logic [IDX_W-1:0] upd_idx;
  tag_t             lkp_tag;
  tag_t             upd_tag;
  logic             lkp_hit;
  logic             upd_hit;
  logic             unused_lsb;

  assign lkp_idx    = lkp_pc_i[IDX_W+1:2];
  assign lkp_tag    = lkp_pc_i[XLEN-1:IDX_W+2];
  assign upd_idx    = upd_pc_i[IDX_W+1:2];
  assign upd_tag    = upd_pc_i[XLEN-1:IDX_W+2];
  assign unused_lsb = ^{lkp_pc_i[1:0], upd_pc_i[1:0]};

  assign lkp_hit      = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
  assign lkp_taken_o  = lkp_hit && cnt_q[lkp_idx][1];
  assign lkp_target_o = target_q[lkp_idx];

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (upd_vld_i) begin
      if (upd_hit) begin
        cnt_d[upd_idx] = cnt_step(cnt_q[upd_idx], upd_taken_i);
        if (upd_taken_i) target_d[upd_idx] = upd_target_i;
      end else if (upd_taken_i) begin
        // A taken miss evicts whatever occupies the slot and starts weakly taken.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target_i;
        cnt_d[upd_idx]    = CNT_WT;
      end
    end
  end

  always_ff @(posedge ck_i or negedge rs_n_i) begin
    if (!rs_n_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/if_pc_gen.sv
// Fetch PC generator: registered fetch PC / ROM enable, BTB next-PC prediction when IF_BTB_EN is defined.
// pc_o/ce_o update one edge after corrections; next_pc_o is combinational from pc_o.
// stall_i[0] holds the PC; flush and branch redirect override the stall.
module if_pc_gen
  import if_pc_gen_pkg::*;
#(
  parameter addr_t RESET_PC    = RESET_PC_DEF,
  parameter int    BTB_ENTRIES = 16,
  parameter int    BTB_IDX_W   = $clog2(BTB_ENTRIES)
) (
  input  logic        ck_i,
  input  logic        rs_n_i,
  if_pc_gen_if.slave  bus
);

  logic  ce_q;
  logic  ce_d;
  logic  bse_q;
  logic  bse_d;
  addr_t pc_q;
  addr_t pc_d;
  addr_t pc_inc;
  addr_t next_pc;
  logic  next_taken;
  logic  unused_stall;

  assign pc_inc       = pc_q + 32'd4;
  assign unused_stall = ^bus.stall_i[5:1];

`ifdef IF_BTB_EN
  logic  btb_taken;
  addr_t btb_target;

  if_btb #(
    .ENTRIES (BTB_ENTRIES),
    .IDX_W   (BTB_IDX_W)
  ) u_btb (
    .ck_i         (ck_i),
    .rs_n_i       (rs_n_i),
    .lkp_pc_i     (pc_q),
    .lkp_taken_o  (btb_taken),
    .lkp_target_o (btb_target),
    .upd_vld_i    (bus.bp_update_i),
    .upd_pc_i     (bus.bp_update_pc_i),
    .upd_taken_i  (bus.bp_update_taken_i),
    .upd_target_i (bus.bp_update_target_i)
  );

  assign next_taken = btb_taken;
  assign next_pc    = btb_taken ? btb_target : pc_inc;
`else
  logic unused_btb;

  assign unused_btb = ^{bus.bp_update_i, bus.bp_update_pc_i, bus.bp_update_taken_i,
                        bus.bp_update_target_i, 32'(BTB_ENTRIES), 32'(BTB_IDX_W)};
  assign next_taken = 1'b0;
  assign next_pc    = pc_inc;
`endif

  // The edge that raises ce_q keeps RESET_PC so the first fetch is at RESET_PC.
  always_comb begin
    ce_d  = 1'b1;
    pc_d  = pc_q;
    bse_d = bse_q;
    if (ce_q) begin
      if (bus.flush_i) begin
        pc_d  = bus.flush_pc_i;
        bse_d = 1'b1;
      end else if (bus.branch_redirect_i) begin
        pc_d  = bus.branch_redirect_pc_i;
        bse_d = 1'b1;
      end else if (bus.stall_i[0] != STOP) begin
        pc_d  = next_pc;
        bse_d = 1'b0;
      end
    end
  end

  always_ff @(posedge ck_i or negedge rs_n_i) begin
    if (!rs_n_i) begin
      ce_q  <= 1'b0;
      pc_q  <= RESET_PC;
      bse_q <= 1'b0;
    end else begin
      ce_q  <= ce_d;
      pc_q  <= pc_d;
      bse_q <= bse_d;
    end
  end

  assign bus.pc_o              = pc_q;
  assign bus.ce_o              = ce_q;
  assign bus.next_pc_o         = next_pc;
  assign bus.next_taken_o      = next_taken;
  assign bus.branch_slot_end_o = bse_q;

endmodule

// File: tb/tb_if_pc_gen.sv
// Directed bench for if_pc_gen: expected fetch PCs are queued as stimulus is driven and popped after each edge.
// Prediction expectations follow the IF_BTB_EN build setting.
module tb_if_pc_gen;
  import if_pc_gen_pkg::*;

  logic ck_i   = 1'b0;
  logic rs_n_i = 1'b0;

  if_pc_gen_if bus ();

  if_pc_gen #(
    .RESET_PC    (32'h0000_0100),
    .BTB_ENTRIES (16)
  ) dut (
    .ck_i   (ck_i),
    .rs_n_i (rs_n_i),
    .bus    (bus)
  );

  always #5 ck_i = ~ck_i;

  typedef struct {
    logic [31:0] pc;
    logic        ce;
    logic        bse;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] mp;
  logic [31:0] exp_npc;
  logic        exp_tk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] pc, input logic bse);
    exp_t e;
    e.pc  = pc;
    e.ce  = 1'b1;
    e.bse = bse;
    sb.push_back(e);
    mp = pc;
  endtask

  task automatic step(input string tag);
    exp_t e;
    @(posedge ck_i);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_pc"},  bus.pc_o,              e.pc);
      chk({tag, "_ce"},  {31'b0, bus.ce_o},     {31'b0, e.ce});
      chk({tag, "_bse"}, {31'b0, bus.branch_slot_end_o}, {31'b0, e.bse});
    end
  endtask

  task automatic idle();
    bus.stall_i              = {5'b0, NO_STOP};
    bus.flush_i              = 1'b0;
    bus.flush_pc_i           = '0;
    bus.branch_redirect_i    = 1'b0;
    bus.branch_redirect_pc_i = '0;
    bus.bp_update_i          = 1'b0;
    bus.bp_update_pc_i       = '0;
    bus.bp_update_taken_i    = 1'b0;
    bus.bp_update_target_i   = '0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.branch_redirect_i    = 1'b1;
    bus.branch_redirect_pc_i = pc;
  endtask

  task automatic bp_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bus.bp_update_i        = 1'b1;
    bus.bp_update_pc_i     = pc;
    bus.bp_update_taken_i  = taken;
    bus.bp_update_target_i = tgt;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    repeat (2) @(posedge ck_i);
    #1;
    chk("rst_pc",  bus.pc_o, 32'h100);
    chk("rst_ce",  {31'b0, bus.ce_o}, 32'd0);
    chk("rst_bse", {31'b0, bus.branch_slot_end_o}, 32'd0);
    chk("rst_npc", bus.next_pc_o, 32'h104);
    chk("rst_ntk", {31'b0, bus.next_taken_o}, 32'd0);

    rs_n_i = 1'b1;
    push(32'h100, 1'b0); step("boot");
    push(32'h104, 1'b0); step("seq1");
    chk("seq_npc", bus.next_pc_o, 32'h108);
    chk("seq_ntk", {31'b0, bus.next_taken_o}, 32'd0);
    push(32'h108, 1'b0); step("seq2");

    bus.stall_i = {5'b0, STOP};
    repeat (3) begin
      push(32'h108, 1'b0); step("stall");
    end
    bus.stall_i = {5'b0, NO_STOP};
    push(32'h10C, 1'b0); step("unstall");

    // Flush beats redirect beats stall.
    bus.stall_i    = {5'b0, STOP};
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = 32'h200;
    redirect(32'h300);
    push(32'h200, 1'b1); step("flush");
    idle();
    push(32'h204, 1'b0); step("post_flush");

    bp_upd(32'h10C, 1'b1, 32'h180);
    push(32'h208, 1'b0); step("upd_taken");
    idle();
    redirect(32'h10C);
    push(32'h10C, 1'b1); step("redir_a");
    idle();
`ifdef IF_BTB_EN
    exp_npc = 32'h180; exp_tk = 1'b1;
`else
    exp_npc = 32'h110; exp_tk = 1'b0;
`endif
    chk("pred_npc", bus.next_pc_o, exp_npc);
    chk("pred_tk",  {31'b0, bus.next_taken_o}, {31'b0, exp_tk});
    push(exp_npc, 1'b0); step("follow");

    repeat (2) begin
      bp_upd(32'h10C, 1'b0, 32'h0);
      push(mp + 32'd4, 1'b0); step("upd_nt");
    end
    idle();
    redirect(32'h10C);
    push(32'h10C, 1'b1); step("redir_b");
    idle();
    chk("nt_npc", bus.next_pc_o, 32'h110);
    chk("nt_tk",  {31'b0, bus.next_taken_o}, 32'd0);

    // Hit+taken from counter 0 must only bump to 1, not reallocate.
    bp_upd(32'h10C, 1'b1, 32'h180);
    push(32'h110, 1'b0); step("cnt_up1");
    idle();
    redirect(32'h10C);
    push(32'h10C, 1'b1); step("redir_c");
    idle();
    bp_upd(32'h10C, 1'b1, 32'h1C0);
    chk("same_cyc_npc", bus.next_pc_o, 32'h110);
    chk("same_cyc_tk",  {31'b0, bus.next_taken_o}, 32'd0);
    push(32'h110, 1'b0); step("cnt_up2");
    idle();
    redirect(32'h10C);
    push(32'h10C, 1'b1); step("redir_d");
    idle();
`ifdef IF_BTB_EN
    exp_npc = 32'h1C0; exp_tk = 1'b1;
`else
    exp_npc = 32'h110; exp_tk = 1'b0;
`endif
    chk("retgt_npc", bus.next_pc_o, exp_npc);
    chk("retgt_tk",  {31'b0, bus.next_taken_o}, {31'b0, exp_tk});
    push(exp_npc, 1'b0); step("retgt_follow");

    redirect(32'hFFFF_FFFC);
    push(32'hFFFF_FFFC, 1'b1); step("redir_top");
    idle();
    chk("wrap_npc", bus.next_pc_o, 32'h0);
    push(32'h0, 1'b0); step("wrap");
    push(32'h4, 1'b0); step("wrap_next");

    // Asynchronous reset between edges, with an update in flight.
    redirect(32'h300);
    push(32'h300, 1'b1); step("redir_e");
    idle();
    bp_upd(32'h10C, 1'b1, 32'h2C0);
    #2;
    rs_n_i = 1'b0;
    #1;
    chk("arst_pc",  bus.pc_o, 32'h100);
    chk("arst_ce",  {31'b0, bus.ce_o}, 32'd0);
    chk("arst_bse", {31'b0, bus.branch_slot_end_o}, 32'd0);
    idle();
    rs_n_i = 1'b1;
    push(32'h100, 1'b0); step("reboot");
    redirect(32'h10C);
    push(32'h10C, 1'b1); step("redir_f");
    idle();
    chk("cleared_npc", bus.next_pc_o, 32'h110);
    chk("cleared_tk",  {31'b0, bus.next_taken_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_pc_gen.md
Name: if_pc_gen

Overview:
- Fetch-stage PC generator sitting directly upstream of the IF/ID pipeline register.
- Holds the architectural fetch PC and drives the instruction ROM address and chip-enable.
- Produces a predicted next PC from a small direct-mapped BTB with 2-bit counters.
- Applies flush and branch-redirect corrections from CTRL/EX and feeds pc, next_pc, next_taken and branch_slot_end to IF/ID.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- BTB_ENTRIES, 16, number of BTB entries; power of two, minimum 2.
- BTB_IDX_W, log2(BTB_ENTRIES), index width; index = pc[BTB_IDX_W+1:2].

Ports:
- ck_i  in  1  clock, all state on rising edge.
- rs_n_i  in  1  reset, asynchronous, active-low.
- stall_i  in  6  CTRL stall vector; bit0 = PC stage stop.
- flush_i  in  1  CTRL exception/flush request.
- flush_pc_i  in  32  flush target address.
- branch_redirect_i  in  1  EX mispredict correction.
- branch_redirect_pc_i  in  32  correct fetch address.
- bp_update_i  in  1  EX resolved a branch this cycle.
- bp_update_pc_i  in  32  PC of the resolved branch.
- bp_update_taken_i  in  1  actual outcome.
- bp_update_target_i  in  32  actual taken target.
- pc_o  out  32  current fetch PC, registered; also ROM address.
- ce_o  out  1  ROM chip enable, registered.
- next_pc_o  out  32  predicted successor of pc_o, combinational from the BTB.
- next_taken_o  out  1  prediction was taken.
- branch_slot_end_o  out  1  first valid fetch after a redirect or flush.

Behaviour:
- Reset (rs_n_i = 0, asynchronous):
  - pc_o = RESET_PC, ce_o = 0, branch_slot_end_o = 0.
  - All BTB valid bits = 0; counters = 2'b01.
- First edge after reset release: ce_o <= 1 and pc_o stays RESET_PC, so the first fetched instruction is at RESET_PC.
- PC update priority when ce_o = 1, highest first:
  1. flush_i: pc_o <= flush_pc_i, branch_slot_end_o <= 1.
  2. branch_redirect_i: pc_o <= branch_redirect_pc_i, branch_slot_end_o <= 1.
  3. stall_i[0] = STOP: pc_o and branch_slot_end_o hold.
  4. Otherwise: pc_o <= next_pc_o, branch_slot_end_o <= 0.
- Flush and redirect override stall.
- Prediction (combinational on pc_o):
  - Hit = valid[idx] and tag[idx] == pc_o[31:BTB_IDX_W+2].
  - If hit and counter[idx][1] = 1: next_pc_o = target[idx], next_taken_o = 1.
  - Else: next_pc_o = pc_o + 4 (mod 2^32, wraps 32'hFFFF_FFFC to 0), next_taken_o = 0.
- BTB update on rising edge when bp_update_i = 1:
  - Hit and taken: counter saturating +1 (max 3); target <= bp_update_target_i.
  - Hit and not taken: counter saturating -1 (min 0).
  - Miss and taken: allocate/replace the entry with valid = 1, new tag, new target, counter = 2'b10.
  - Miss and not taken: no change.
- Update and lookup of the same index in the same cycle: the lookup sees the pre-update contents; the write takes effect next cycle.
- Updates proceed during stall, flush and redirect.
- Asynchronous reset mid-operation: immediate return to the reset values; any in-flight update is lost.
- Arithmetic: pc + 4 is 32-bit unsigned; pc bits [1:0] are assumed 0 and not checked.

Optional Feature:
- Macro: IF_BTB_EN.
- Defined: BTB and update logic as described above.
- Undefined:
  - No BTB storage; bp_update_* inputs are ignored.
  - next_pc_o = pc_o + 4 and next_taken_o = 0 always.
  - Flush, redirect and stall behaviour is unchanged.

Decomposition:
- Shared package/defines:
  - RESET_PC default.
  - 32-bit instruction-address bus width.
  - STOP/NO_STOP encodings.
  - 2-bit counter encodings: SNT = 0, WNT = 1, WT = 2, ST = 3.
- Sub-module if_btb holds the valid/tag/target/counter arrays, the lookup port and the update port.
- if_btb is instantiated only under IF_BTB_EN.

Test Plan:
- Reset with RESET_PC = 32'h100, release, no stalls -> ce_o rises; pc_o sequence 100, 104, 108; next_taken_o = 0; branch_slot_end_o = 0.
- stall_i = 6'b000001 for 3 cycles at pc_o = 32'h108 -> pc_o holds 108 for 3 cycles, then advances to 10C.
- flush_i = 1 with flush_pc_i = 32'h200 while branch_redirect_i = 1 with pc 32'h300 and stall_i[0] = 1 -> pc_o = 200 next cycle; branch_slot_end_o pulses for one cycle.
- bp_update of pc 32'h10C taken, target 32'h180; later fetch reaches 10C -> next_pc_o = 180, next_taken_o = 1; pc_o follows 10C then 180.
- Two not-taken updates to pc 10C (counter 2 -> 1 -> 0) -> next fetch of 10C predicts 110 with next_taken_o = 0; entry stays valid.
- pc_o = 32'hFFFF_FFFC, no BTB hit -> next pc_o = 32'h0000_0000.
- Build without IF_BTB_EN, repeating the taken update above -> next_pc_o remains 110 at 10C.
